// File: rtl/tt_debias_multi.sv
// tt_debias_multi: multi-lane TRNG debiaser (von Neumann or XOR corrector),
// a bit collector that packs the surviving bits into OUT_W-bit words, and a
// small output FIFO with a valid/ready drain.
// Optional feature macro: TT_HEALTH_EN adds a per-lane repetition-count
// health test. When it is undefined, health_fail is tied to zero.
module tt_debias_multi #(
    parameter int LANES      = 4,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            mode,
    input  logic                            clear,
    input  logic [LANES-1:0]                raw_in,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [LANES-1:0]                health_fail
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam int POS_W = $clog2(2 * OUT_W);

    // Per-lane results of the current edge.
    logic [LANES-1:0] emit_vld;
    logic [LANES-1:0] emit_bit;
    logic [LANES-1:0] lane_ok;

    // ------------------------------------------------------------------
    // Lane pairing and optional health test
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic phase_reg;
            logic first_reg;

            // Phase toggles on every enabled edge; the first bit of a pair is kept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    phase_reg <= 1'b0;
                    first_reg <= 1'b0;
                end else if (clear) begin
                    phase_reg <= 1'b0;
                    first_reg <= 1'b0;
                end else if (en) begin
                    phase_reg <= ~phase_reg;
                    if (!phase_reg) begin
                        first_reg <= raw_in[gi];
                    end
                end
            end

            // The pair resolves on the second enabled sample: XOR mode always
            // emits a^b, von Neumann emits a only when the two bits differ.
            assign emit_bit[gi] = mode ? (first_reg ^ raw_in[gi]) : first_reg;
            assign emit_vld[gi] = en & phase_reg & lane_ok[gi] &
                                  (mode | (first_reg ^ raw_in[gi]));

`ifdef TT_HEALTH_EN
            localparam int RC_W = $clog2(REP_LIMIT + 1);
            logic            prev_reg;
            logic            have_prev_reg;
            logic [RC_W-1:0] rep_cnt_reg;
            logic [RC_W-1:0] rep_cnt_next;
            logic            fail_reg;

            // Run length of identical samples, restarting at 1 on any change.
            always_comb begin
                rep_cnt_next = rep_cnt_reg;
                if (!have_prev_reg || (raw_in[gi] != prev_reg)) begin
                    rep_cnt_next = RC_W'(1);
                end else if (rep_cnt_reg != RC_W'(REP_LIMIT)) begin
                    rep_cnt_next = rep_cnt_reg + RC_W'(1);
                end
            end

            // Repetition counter state and the sticky failure flag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg      <= 1'b0;
                    have_prev_reg <= 1'b0;
                    rep_cnt_reg   <= '0;
                    fail_reg      <= 1'b0;
                end else if (clear) begin
                    prev_reg      <= 1'b0;
                    have_prev_reg <= 1'b0;
                    rep_cnt_reg   <= '0;
                    fail_reg      <= 1'b0;
                end else if (en) begin
                    prev_reg      <= raw_in[gi];
                    have_prev_reg <= 1'b1;
                    rep_cnt_reg   <= rep_cnt_next;
                    if (rep_cnt_next == RC_W'(REP_LIMIT)) begin
                        fail_reg <= 1'b1;
                    end
                end
            end

            assign lane_ok[gi]     = ~fail_reg;
            assign health_fail[gi] = fail_reg;
`else
            assign lane_ok[gi]     = 1'b1;
            assign health_fail[gi] = 1'b0;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Collector
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]   data_reg;
    logic [OUT_W-1:0]   data_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [2*OUT_W-1:0] ext;
    logic [POS_W-1:0]   pos;
    logic               word_done;
    logic [OUT_W-1:0]   push_word;

    // Append emitted bits in lane order above the current fill level; the
    // double-width buffer holds the overflow into the next word.
    always_comb begin
        ext = {{OUT_W{1'b0}}, data_reg};
        pos = POS_W'(count_reg);
        for (int l = 0; l < LANES; l++) begin
            if (emit_vld[l]) begin
                ext[pos] = emit_bit[l];
                pos      = pos + POS_W'(1);
            end
        end
        word_done = (pos >= POS_W'(OUT_W));
        push_word = ext[OUT_W-1:0];
        if (word_done) begin
            data_next  = ext[2*OUT_W-1:OUT_W];
            count_next = CNT_W'(pos - POS_W'(OUT_W));
        end else begin
            data_next  = ext[OUT_W-1:0];
            count_next = CNT_W'(pos);
        end
    end

    // Collector fill level and partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            count_reg <= '0;
        end else if (clear) begin
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            data_reg  <= data_next;
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             overflow_reg;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // accepted in that case.
    assign push_ok = word_done & (~full | pop);

    // Storage; write only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            if (word_done && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_valid  = (level_reg != '0);
    assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;

endmodule

// File: doc/tt_debias_multi.md
Name: tt_debias_multi

Overview:
- Parametrised multi-lane entropy debiaser for raw TRNG bitstreams.
- Each lane pairs consecutive raw samples and applies one of two corrections:
  - von Neumann extraction: emit first bit of a differing pair, discard equal pairs.
  - XOR correction: emit a^b for every pair.
- Surviving bits from all lanes are packed into OUT_W-bit words and buffered in a FIFO.
- The FIFO drains through a valid/ready handshake to the downstream consumer.

Parameters:
- LANES, 4, number of independent raw entropy inputs (1..8).
- OUT_W, 8, output word width in bits; must be >= LANES.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).
- REP_LIMIT, 16, repetition-count health threshold; used only with TT_HEALTH_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; raw_in is sampled only on edges where en=1.
- mode  in  1  0 = von Neumann, 1 = XOR corrector; sampled at each pair completion.
- clear  in  1  synchronous clear of all state except configuration; priority over all other activity.
- raw_in  in  LANES  raw entropy bits, one per lane.
- out_data  out  OUT_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a completed word was dropped.
- health_fail  out  LANES  sticky per-lane health failure.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all lane phases = first-bit; collector count = 0, data = 0.
  - FIFO empty; out_valid=0, out_data=0, fifo_level=0, overflow=0, health_fail=0.
- clear=1: same state as reset, applied at the clock edge; any pop or push in that cycle is ignored.
- Lane pairing:
  - Per-lane phase bit toggles on every en=1 edge.
  - First sample of a pair is stored.
  - On the second sample, the pair (a=stored, b=raw_in) resolves in the same edge.
    - mode=0: emit a when a!=b; emit nothing when a==b.
    - mode=1: always emit a^b.
- en=0: no sampling, phases hold, partial pairs are kept indefinitely.
- Collector:
  - k = number of bits emitted this edge (0..LANES).
  - Bits are inserted in ascending lane order at bit index count, LSB first.
  - If count+k < OUT_W: count += k.
  - If count+k >= OUT_W: the filled word is pushed to the FIFO in the same edge. The leftover count+k-OUT_W bits start the next word at bit 0, and count = the leftover count.
- FIFO push/pop:
  - Pop occurs on an edge where out_valid & out_ready.
  - A push while full without a simultaneous pop drops the word and sets overflow; the collector still advances.
  - A push while full with a simultaneous pop is accepted.
  - A pop while empty is not possible (out_valid=0).
- Outputs:
  - out_data, out_valid and fifo_level are registered FIFO state.
  - A word pushed at edge N is visible from edge N onward, i.e. out_valid is seen high in cycle N+1.
  - out_data is stable while out_valid=1 and out_ready=0.
- Mode: a change of mode mid-pair applies to that pair's resolution; no flush occurs.
- Latency, LANES=1, OUT_W=8, mode=1: first word after 16 enabled edges.

Optional Feature:
- TT_HEALTH_EN defined:
  - Each lane has a repetition counter over enabled samples, reset to 1 when a sample differs from the previous one.
  - When the counter reaches REP_LIMIT, health_fail[lane] is set; it stays set until clear or reset.
  - A failed lane emits no bits into the collector.
- TT_HEALTH_EN undefined: no counters; health_fail tied to 0; all lanes always contribute.

Test Plan:
- LANES=1, OUT_W=8, mode=0, en=1, raw 1,0 repeated for 16 edges -> one word 0xFF, out_valid high after edge 16, fifo_level=1.
- LANES=1, mode=0, raw 1,1,0,0 repeated for 64 edges -> no words; out_valid stays 0, collector count stays 0.
- LANES=4, OUT_W=8, mode=1, raw_in=4'b0101 on the first edge and 4'b0011 on the second, then repeated -> lanes emit 0,1,1,0 per pair; word 0x66 after 4 edges.
- FIFO_DEPTH=4, out_ready=0, continuous words -> fifo_level saturates at 4, the fifth word is dropped and overflow=1. Then raise out_ready -> 4 words drain in order; overflow stays 1 until clear.
- Full FIFO with out_ready=1 on the same edge a word completes -> push accepted, level stays 4, no overflow. rst_n low mid-word -> all outputs 0 immediately, without waiting for a clock edge.
- TT_HEALTH_EN, REP_LIMIT=16, lane 2 held at 1 -> health_fail=4'b0100 after the 16th enabled sample, lane 2 contributes no bits; clear pulse -> health_fail=0.
